// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared constants and types for the LED PWM fader.
//                PWM_BITS / DUTY_MAX size the duty and PWM counter paths.
//                DEF_PWM_PRESCALE / DEF_RAMP_DIV are the default timing
//                parameters of led_pwm_fader.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int PWM_BITS         = 8;
    localparam int DUTY_MAX         = 255;
    localparam int DEF_PWM_PRESCALE = 4;
    localparam int DEF_RAMP_DIV     = 39_216;
    localparam int NUM_CH           = 2;

    typedef logic [PWM_BITS-1:0] duty_t;

    // Full-scale duty as a correctly sized constant, so that comparisons
    // against 8-bit duty values stay width-matched.
    localparam duty_t DUTY_FULL = duty_t'(DUTY_MAX);

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_channel
//  Description : One fader channel. It holds the duty register, steps it by
//                one LSB toward the on/off target on each ramp step, and
//                drives a registered PWM output from the shared PWM counter.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                en             - output enable (0 forces pwm_out low)
//                step           - one-cycle ramp strobe (already gated by en)
//                target_on      - 1 targets full duty, 0 targets zero duty
//                pwm_cnt        - shared free-running PWM counter
//                pwm_out        - registered PWM drive
//                busy           - combinational: duty differs from target
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_channel
    import led_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  step,
    input  logic  target_on,
    input  duty_t pwm_cnt,
    output logic  pwm_out,
    output logic  busy
);

    duty_t duty;
    duty_t duty_nxt;
    duty_t target;

    // The target is recomputed every cycle, so a mid-ramp flip simply changes
    // the direction of the next step; the duty itself never jumps.
    assign target = target_on ? DUTY_FULL : '0;

    always_comb begin
        duty_nxt = duty;
        if (step) begin
            if (duty < target) begin
                duty_nxt = duty + 8'd1;
            end else if (duty > target) begin
                duty_nxt = duty - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            duty    <= duty_nxt;
            // Full duty is forced high explicitly: with an 8-bit counter the
            // plain "duty > pwm_cnt" test would drop low when pwm_cnt = 255.
            pwm_out <= en && ((duty == DUTY_FULL) || (duty > pwm_cnt));
        end
    end

    assign busy = (duty != target);

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_fader
//  Description : Two-channel LED fader. It turns the on/off pattern from the
//                LED flasher into PWM outputs whose duty ramps linearly
//                between 0 and 255. The prescaler, PWM counter and ramp
//                counter are shared, so both channels stay phase-aligned.
//  Parameters  : PWM_PRESCALE - clk cycles per PWM counter increment
//                RAMP_DIV     - clk cycles per one-LSB duty step
//  Ports       : clk, rst_n - clock, async active-low reset
//                led_in[1:0] - per-channel on request
//                en          - output enable; 0 clears counters, holds duty
//                pwm_out[1:0]- registered PWM drive
//                busy        - registered; any channel still ramping
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int PWM_PRESCALE = DEF_PWM_PRESCALE,
    parameter int RAMP_DIV     = DEF_RAMP_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] led_in,
    input  logic              en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              busy
);

    localparam logic [15:0] PRE_LAST  = 16'(PWM_PRESCALE - 1);
    localparam logic [23:0] RAMP_LAST = 24'(RAMP_DIV - 1);

    logic [15:0]       pre_cnt;
    logic [23:0]       ramp_cnt;
    duty_t             pwm_cnt;
    logic              pwm_tick;
    logic              ramp_step;
    logic [NUM_CH-1:0] ch_busy;

    assign pwm_tick  = en && (pre_cnt == PRE_LAST);
    assign ramp_step = en && (ramp_cnt == RAMP_LAST);

    // Disabling clears all timing state, so re-enabling restarts PWM and ramp
    // phase from zero; the duty registers in the channels are left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
            busy     <= 1'b0;
        end else if (!en) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            pre_cnt  <= pwm_tick ? '0 : pre_cnt + 16'd1;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            ramp_cnt <= ramp_step ? '0 : ramp_cnt + 24'd1;
            busy     <= |ch_busy;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .step      (ramp_step),
            .target_on (led_in[i]),
            .pwm_cnt   (pwm_cnt),
            .pwm_out   (pwm_out[i]),
            .busy      (ch_busy[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_led_pwm_fader
//  Description : Bench for led_pwm_fader. Instance A uses PWM_PRESCALE=1,
//                RAMP_DIV=4; instance B uses PWM_PRESCALE=3, RAMP_DIV=1.
//                Expected outputs come from a cycle-count reference model:
//                PWM count = (cycles/PRESCALE) mod 256, a ramp step lands on
//                every RAMP_DIV-th enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    localparam int P_A = 1;
    localparam int R_A = 4;
    localparam int P_B = 3;
    localparam int R_B = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a  = 1'b0;
    logic       en_b  = 1'b0;
    logic [1:0] led_a = 2'b00;
    logic [1:0] led_b = 2'b00;
    logic [1:0] pwm_a;
    logic [1:0] pwm_b;
    logic       busy_a;
    logic       busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(.PWM_PRESCALE(P_A), .RAMP_DIV(R_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .led_in(led_a), .en(en_a),
        .pwm_out(pwm_a), .busy(busy_a)
    );

    led_pwm_fader #(.PWM_PRESCALE(P_B), .RAMP_DIV(R_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .led_in(led_b), .en(en_b),
        .pwm_out(pwm_b), .busy(busy_b)
    );

    // ------------------------------------------------------------------
    // Reference model: n = enabled cycles since the last clear.
    // ------------------------------------------------------------------
    typedef struct packed {
        int         n;
        logic [7:0] d1;
        logic [7:0] d0;
        logic [1:0] out;
        logic       busy;
    } model_t;

    model_t ma;
    model_t mb;

    function automatic int toward(int d, int t);
        if (t > d) return d + 1;
        if (t < d) return d - 1;
        return d;
    endfunction

    function automatic model_t step(model_t m, int p, int r, logic [1:0] led, logic e);
        model_t s;
        int pc, d0, d1, t0, t1;
        s  = m;
        pc = (m.n / p) % 256;
        d0 = int'(m.d0);
        d1 = int'(m.d1);
        t0 = led[0] ? 255 : 0;
        t1 = led[1] ? 255 : 0;
        s.out[0] = e && (d0 == 255 || d0 > pc);
        s.out[1] = e && (d1 == 255 || d1 > pc);
        s.busy   = e && (d0 != t0 || d1 != t1);
        if (e && (m.n % r) == r - 1) begin
            d0 = toward(d0, t0);
            d1 = toward(d1, t1);
        end
        s.d0 = 8'(d0);
        s.d1 = 8'(d1);
        s.n  = e ? m.n + 1 : 0;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, P_A, R_A, led_a, en_a);
            mb <= step(mb, P_B, R_B, led_b, en_b);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pwm_a",  {30'd0, pwm_a},  {30'd0, ma.out});
        chk("busy_a", {31'd0, busy_a}, {31'd0, ma.busy});
        chk("pwm_b",  {30'd0, pwm_b},  {30'd0, mb.out});
        chk("busy_b", {31'd0, busy_b}, {31'd0, mb.busy});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic bound_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_d1(input int v);
        int k;
        k = 0;
        while (int'(ma.d1) != v && k < 3000) begin
            cycles(1);
            k++;
        end
        if (k >= 3000) bound_fail("wait_d1");
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;
        int c0;
        int c1;

        // Reset with channel 1 requested on, enable high.
        en_a  = 1'b1;
        led_a = 2'b10;
        repeat (3) @(negedge clk);
        chk("rst_pwm_a",  {30'd0, pwm_a},  32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_pwm_b",  {30'd0, pwm_b},  32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        rst_n = 1'b1;

        // Ramp to full: duty reaches 255 on edge 1020, busy clears on 1021.
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            check_all();
            k++;
            if (busy_a === 1'b0) break;
        end
        chk("busy_fall_cycle", k, 32'd1021);
        cycles(300);

        // Fall to 100, then swap channels: 1 falls from 100, 0 rises from 0.
        led_a = 2'b00;
        wait_d1(100);
        led_a = 2'b01;
        cycles(600);

        // Rise channel 1 to 77 and disable for 20 cycles.
        led_a = 2'b10;
        wait_d1(77);
        en_a = 1'b0;
        @(negedge clk);
        check_all();
        chk("dis_pwm_a",  {30'd0, pwm_a},  32'd0);
        chk("dis_busy_a", {31'd0, busy_a}, 32'd0);
        cycles(19);
        en_a = 1'b1;
        cycles(400);

        // Asynchronous reset mid-ramp at duty 200.
        wait_d1(200);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm_a",  {30'd0, pwm_a},  32'd0);
        chk("async_rst_busy_a", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycles(600);

        // Instance B: R=1 ramps in 255 cycles; PWM period is 3*256 cycles.
        en_b  = 1'b1;
        led_b = 2'b01;
        cycles(300);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 768; i++) begin
            @(negedge clk);
            check_all();
            c0 += int'(pwm_b[0]);
            c1 += int'(pwm_b[1]);
        end
        chk("b_full_highs", c0, 32'd768);
        chk("b_zero_highs", c1, 32'd0);
        led_b = 2'b10;
        cycles(300);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 768; i++) begin
            @(negedge clk);
            check_all();
            c0 += int'(pwm_b[0]);
            c1 += int'(pwm_b[1]);
        end
        chk("b_zero_highs2", c0, 32'd0);
        chk("b_full_highs2", c1, 32'd768);

        // Randomized pattern and enable activity on both instances.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0)  led_a = 2'($urandom);
            if ($urandom_range(0, 49) == 0)  led_b = 2'($urandom);
            if ($urandom_range(0, 149) == 0) en_a  = ~en_a;
            if ($urandom_range(0, 149) == 0) en_b  = ~en_b;
            cycles(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
